// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_LOAD = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first eligible channel after last_grant wins.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [IW-1:0]   last_grant,
  output logic            any,
  output logic [IW-1:0]   winner
);

  int   idx;
  logic found;

  assign any = |eligible;

  // Walk last_grant+1 .. last_grant+N_CH so the previous winner is tried last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant) + k) % N_CH;
      if (!found && eligible[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Drains N_CH channel FIFOs round-robin into one valid/ready output stream,
// one word per grant: pick, pop, load the read data, then hold until accepted.
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ch_empty,
  input  logic [N_CH*WIDTH-1:0]     ch_rd_data,
  input  logic [N_CH-1:0]           ch_mask,
  output logic [N_CH-1:0]           ch_pop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch_id
);

  localparam int IW = $clog2(N_CH);

  state_t          state;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   last_grant;
  logic [N_CH-1:0] eligible;
  logic [IW-1:0]   pick_base;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;

  assign eligible = ~ch_empty & ch_mask;

  // While a beat is being accepted, sel is about to become last_grant, so search from it directly.
  assign pick_base = (state == S_OUT) ? sel : last_grant;

  rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (pick_base),
    .any        (pick_any),
    .winner     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= '0;
      last_grant <= IW'(N_CH - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch_id  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            state <= S_POP;
          end
        end
        S_POP: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          out_data  <= ch_rd_data[int'(sel)*WIDTH +: WIDTH];
          out_ch_id <= sel;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            last_grant <= sel;
            out_valid  <= 1'b0;
            if (pick_any) begin
              sel   <= pick_idx;
              state <= S_POP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_pop = '0;
    if (state == S_POP) ch_pop[sel] = 1'b1;
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched with a scoreboard checking every accepted beat.
module tb_fifo_rr_sched;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       ch_empty = '1;
  logic [N_CH*WIDTH-1:0] ch_rd_data = '0;
  logic [N_CH-1:0]       ch_mask = '1;
  logic [N_CH-1:0]       ch_pop;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_ch_id;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];

  fifo_rr_sched #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_empty   (ch_empty),
    .ch_rd_data (ch_rd_data),
    .ch_mask    (ch_mask),
    .ch_pop     (ch_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch_id  (out_ch_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] empty, input logic [3:0] mask, input logic ready);
    ch_empty  = empty;
    ch_mask   = mask;
    out_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] id);
    logic [3:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Monitor: any beat the DUT hands off at the next edge must match the queue head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_ch_id", 32'(out_ch_id), 32'(e.id));
          checkOutput("beat_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] seq [5];
    logic [7:0] dat [4];
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;

    // Reset held two cycles with every channel full.
    applyStimulus(4'b0000, 4'hF, 1'b0);
    rst = 1'b1;
    tick(); tick();
    checkOutput("reset_pop", 32'(ch_pop), 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_data", 32'(out_data), 32'h0);
    checkOutput("reset_ch_id", 32'(out_ch_id), 32'h0);

    // Single beat from channel 2.
    ch_rd_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    applyStimulus(4'b1011, 4'hF, 1'b1);
    exp_q.push_back('{id: 2'd2, data: 8'hA5});
    rst = 1'b0;
    tick();
    checkOutput("single_pop", 32'(ch_pop), 32'b0100);
    tick();
    checkOutput("single_pop_once", 32'(ch_pop), 32'h0);
    checkOutput("single_valid_early", 32'(out_valid), 32'h0);
    ch_empty = 4'hF;
    tick();
    checkOutput("single_valid", 32'(out_valid), 32'h1);
    checkOutput("single_data", 32'(out_data), 32'hA5);
    checkOutput("single_ch_id", 32'(out_ch_id), 32'h2);
    tick();
    checkOutput("single_done", 32'(out_valid), 32'h0);

    // Fairness after reset: 0,1,2,3,0 with a pop every third cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ch_rd_data = {dat[3], dat[2], dat[1], dat[0]};
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    for (int i = 0; i < 5; i++) exp_q.push_back('{id: seq[i], data: dat[seq[i]]});
    applyStimulus(4'b0000, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("fair_pop%0d", i), 32'(ch_pop), 32'(onehot(seq[i])));
      if (i == 4) ch_empty = 4'hF;
      tick();
      tick();
    end
    tick();
    checkOutput("fair_idle_valid", 32'(out_valid), 32'h0);
    checkOutput("fair_idle_pop", 32'(ch_pop), 32'h0);

    // Backpressure: hold channel 1's beat for 10 cycles, then release.
    exp_q.push_back('{id: 2'd1, data: dat[1]});
    applyStimulus(4'b0000, 4'hF, 1'b0);
    tick();
    checkOutput("bp_pop", 32'(ch_pop), 32'b0010);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_hold%0d", i), {21'h0, out_valid, out_ch_id, out_data}, {21'h0, 1'b1, 2'd1, dat[1]});
      checkOutput($sformatf("bp_nopop%0d", i), 32'(ch_pop), 32'h0);
      tick();
    end
    exp_q.push_back('{id: 2'd2, data: dat[2]});
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_pop", 32'(ch_pop), 32'b0100);
    ch_empty = 4'hF;
    tick(); tick(); tick();
    checkOutput("bp_done", 32'(out_valid), 32'h0);

    // Mask 0101: grants alternate between channels 0 and 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd0; seq[3] = 2'd2;
    for (int i = 0; i < 4; i++) exp_q.push_back('{id: seq[i], data: dat[seq[i]]});
    applyStimulus(4'b0000, 4'b0101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("mask_pop%0d", i), 32'(ch_pop), 32'(onehot(seq[i])));
      if (i == 3) ch_empty = 4'hF;
      tick();
      tick();
    end
    tick();
    checkOutput("mask_done", 32'(out_valid), 32'h0);

    // Reset in the pop cycle discards the beat; the next grant restarts at channel 0.
    applyStimulus(4'b0000, 4'hF, 1'b1);
    tick();
    checkOutput("mid_pop", 32'(ch_pop), 32'b1000);
    rst = 1'b1;
    tick();
    checkOutput("mid_reset_pop", 32'(ch_pop), 32'h0);
    checkOutput("mid_reset_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    exp_q.push_back('{id: 2'd0, data: dat[0]});
    tick();
    checkOutput("mid_regrant", 32'(ch_pop), 32'b0001);
    ch_empty = 4'hF;
    tick(); tick(); tick(); tick();
    checkOutput("mid_done", 32'(out_valid), 32'h0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
